tl_d_responder: RTL
===================

// Module: tl_d_responder
// PURPOSE
// - TileLink-UL manager endpoint. Accepts A-channel Get/PutFullData/PutPartialData
//   and drives the D-channel beats that downstream 2-entry D queues buffer.
// - Backed by a register-array scratchpad of 64-bit words.
// - Sits behind the tile crossbar as a small test/boot scratchpad.
// PARAMETERS
// - ADDR_W    8  byte-address width of scratchpad (2^(ADDR_W-3) words)
// - SINK_ID   0  constant value driven on d_sink[2:0]
// - MAX_SIZE  6  largest legal log2 transfer size (64 B = 8 beats)
// PORTS
// - clock        in   1   clock
// - reset        in   1   reset, synchronous, active-high
// - a_ready      out  1   A beat accepted when a_valid & a_ready
// - a_valid      in   1   A beat valid
// - a_opcode     in   3   0=PutFull 1=PutPartial 4=Get, others illegal
// - a_param      in   3   ignored
// - a_size       in   4   log2 bytes of transfer
// - a_source     in   5   requester ID, echoed on D
// - a_address    in   32  byte address
// - a_mask       in   8   byte lanes written (Put)
// - a_data       in   64  write data
// - a_corrupt    in   1   Put beat poisoned; beat not written
// - d_ready      in   1   D beat consumed when d_valid & d_ready
// - d_valid      out  1   D beat valid
// - d_opcode     out  3   0=AccessAck 1=AccessAckData
// - d_param      out  2   always 0
// - d_size       out  4   echo of a_size
// - d_source     out  5   echo of a_source
// - d_sink       out  3   SINK_ID
// - d_denied     out  1   request rejected
// - d_data       out  64  read data (0 when denied or AccessAck)
// - d_corrupt    out  1   data unusable
// BEHAVIOUR
// - FSM: IDLE, RD (emit Get beats), WR (absorb Put beats), ACK (emit one AccessAck).
// - Reset: state=IDLE; d_valid=0; all d_* regs 0; beat counter 0. Scratchpad not reset.
// - a_ready = (state==IDLE) | (state==WR). Combinational from state only.
// - beats = (a_size>3) ? 1<<(a_size-3) : 1. Counter is 3 bits; last beat at cnt==beats-1.
// - Denied if any of: opcode illegal; a_size>MAX_SIZE; address not aligned to
//   2^a_size; a_address >= 2^ADDR_W.
// - Request fields (size, source, base word, denied) are latched on the first A beat.
// - IDLE+Get accepted (cycle N): load beat 0 into d_*, d_valid=1 at N+1, go RD.
// - RD: on d_ready, advance; next beat presented the following cycle, with no bubble.
//   d_valid drops after the last beat is taken, then IDLE.
// - Word index for beat k = base_word + k. It stays within the aligned block, so no wrap.
// - d_* are registered and held stable while d_valid & ~d_ready.
// - Denied Get: beats full count; d_opcode=1, d_denied=1, d_corrupt=1, d_data=0.
// - Put: each accepted beat (including the first, in IDLE) writes masked bytes at
//   the same clock edge, unless denied or a_corrupt.
// - Put sequencing: multi-beat Put goes IDLE->WR. After the last beat go ACK.
//   Single-beat Put goes straight to ACK.
// - ACK: d_opcode=0, d_data=0, d_corrupt=0, d_denied per latch. Exits to IDLE on d_ready.
// - Read-after-write: a Get accepted after a Put's AccessAck returns the new data.
// - No A beat is accepted in RD/ACK, so at most one transaction is in flight.
// - Reset mid-burst: transaction abandoned, d_valid=0 next cycle. Writes already done persist.
// CONFIGURATION
// - TL_RESP_ERR_INJECT_EN defined: adds input err_inject (1 bit).
//   - A Get beat loaded while err_inject=1 drives d_corrupt=1 (d_denied unchanged, data real).
//   - A Put beat accepted while err_inject=1 is dropped (not written). Its AccessAck has d_denied=1.
// - TL_RESP_ERR_INJECT_EN undefined: port absent, no injection logic.
// TESTING
// - Reset, then idle: d_valid=0, a_ready=1; after 3 idle cycles still d_valid=0.
// - PutFull size=3 addr=0x10 data=0xA5A5_0000_1234_5678 mask=0xFF
//   -> AccessAck source echoed, denied=0.
// - Get size=3 addr=0x10 -> one AccessAckData beat, data=0xA5A5_0000_1234_5678,
//   d_valid one cycle after accept.
// - PutFull size=5 addr=0x40 beats 1..4, then Get size=5 with d_ready toggling 1,0,1
//   -> 4 beats, data 1..4 in order, each held stable while stalled.
// - Get size=3 addr=0x100 (ADDR_W=8) -> denied=1 corrupt=1 data=0.
//   Get size=4 addr=0x08 (misaligned) -> 2 denied beats.
// - Assert reset during beat 2 of an 8-beat Get -> d_valid=0 next cycle.
//   A following Get addr=0 completes normally.

Source files
------------

// File: rtl/tl_d_responder.sv
// TileLink-UL manager endpoint backed by a 64-bit register-array scratchpad.
// Optional TL_RESP_ERR_INJECT_EN adds err_inject to corrupt Get beats and drop Put beats.
module tl_d_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SINK_ID  = 0,
    parameter int unsigned MAX_SIZE = 6
) (
    input  logic        clock,
    input  logic        reset,
`ifdef TL_RESP_ERR_INJECT_EN
    input  logic        err_inject,
`endif
    output logic        a_ready,
    input  logic        a_valid,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [4:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    input  logic        a_corrupt,
    input  logic        d_ready,
    output logic        d_valid,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic [4:0]  d_source,
    output logic [2:0]  d_sink,
    output logic        d_denied,
    output logic [63:0] d_data,
    output logic        d_corrupt
);
    localparam int unsigned WORD_W = ADDR_W - 3;
    localparam int unsigned WORDS  = 1 << WORD_W;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d, last_q, last_d;
    logic [3:0]         size_q, size_d;
    logic [4:0]         source_q, source_d;
    logic [WORD_W-1:0]  base_q, base_d;
    logic               denied_q, denied_d;
    logic               d_valid_d, d_denied_d, d_corrupt_d;
    logic [2:0]         d_opcode_d;
    logic [3:0]         d_size_d;
    logic [4:0]         d_source_d;
    logic [63:0]        d_data_d;

    logic [63:0]        mem [WORDS];
    logic               wr_en;
    logic [WORD_W-1:0]  wr_idx;

    logic               err_c, is_get, is_put, req_denied;
    logic [31:0]        align_mask;
    logic [2:0]         req_last;
    logic [WORD_W-1:0]  a_word, nxt_idx;
    logic               unused_ok;

`ifdef TL_RESP_ERR_INJECT_EN
    assign err_c = err_inject;
`else
    assign err_c = 1'b0;
`endif

    assign unused_ok  = ^a_param;
    assign a_ready    = (state_q == S_IDLE) || (state_q == S_WR);
    assign d_param    = 2'd0;
    assign d_sink     = 3'(SINK_ID);
    assign is_get     = (a_opcode == 3'd4);
    assign is_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign align_mask = (32'd1 << a_size) - 32'd1;
    assign a_word     = a_address[ADDR_W-1:3];
    assign nxt_idx    = base_q + WORD_W'(cnt_q + 3'd1);
    assign req_denied = !(is_get || is_put) || (a_size > 4'(MAX_SIZE))
                        || (|(a_address & align_mask)) || (|a_address[31:ADDR_W]);

    // Index of the last beat; oversized (denied) requests clamp to the 3-bit counter.
    always_comb begin
        case (a_size)
            4'd0, 4'd1, 4'd2, 4'd3: req_last = 3'd0;
            4'd4:                   req_last = 3'd1;
            4'd5:                   req_last = 3'd3;
            default:                req_last = 3'd7;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            last_q    <= 3'd0;
            size_q    <= 4'd0;
            source_q  <= 5'd0;
            base_q    <= '0;
            denied_q  <= 1'b0;
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_source  <= 5'd0;
            d_denied  <= 1'b0;
            d_data    <= 64'd0;
            d_corrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            size_q    <= size_d;
            source_q  <= source_d;
            base_q    <= base_d;
            denied_q  <= denied_d;
            d_valid   <= d_valid_d;
            d_opcode  <= d_opcode_d;
            d_size    <= d_size_d;
            d_source  <= d_source_d;
            d_denied  <= d_denied_d;
            d_data    <= d_data_d;
            d_corrupt <= d_corrupt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        size_d      = size_q;
        source_d    = source_q;
        base_d      = base_q;
        denied_d    = denied_q;
        d_valid_d   = d_valid;
        d_opcode_d  = d_opcode;
        d_size_d    = d_size;
        d_source_d  = d_source;
        d_denied_d  = d_denied;
        d_data_d    = d_data;
        d_corrupt_d = d_corrupt;
        wr_en       = 1'b0;
        wr_idx      = base_q + WORD_W'(cnt_q);

        case (state_q)
            S_IDLE: begin
                if (a_valid) begin
                    size_d   = a_size;
                    source_d = a_source;
                    base_d   = a_word;
                    denied_d = req_denied;
                    last_d   = req_last;
                    cnt_d    = 3'd0;
                    d_size_d   = a_size;
                    d_source_d = a_source;
                    if (is_get) begin
                        state_d     = S_RD;
                        d_valid_d   = 1'b1;
                        d_opcode_d  = 3'd1;
                        d_denied_d  = req_denied;
                        d_corrupt_d = req_denied || err_c;
                        d_data_d    = req_denied ? 64'd0 : mem[a_word];
                    end else begin
                        // Puts write the first beat now; illegal opcodes get a denied AccessAck.
                        wr_idx   = a_word;
                        wr_en    = is_put && !req_denied && !a_corrupt && !err_c;
                        denied_d = req_denied || err_c;
                        if (is_put && (req_last != 3'd0)) begin
                            state_d = S_WR;
                            cnt_d   = 3'd1;
                        end else begin
                            state_d     = S_ACK;
                            d_valid_d   = 1'b1;
                            d_opcode_d  = 3'd0;
                            d_denied_d  = req_denied || err_c;
                            d_data_d    = 64'd0;
                            d_corrupt_d = 1'b0;
                        end
                    end
                end
            end
            S_WR: begin
                if (a_valid) begin
                    wr_en    = !denied_q && !a_corrupt && !err_c;
                    denied_d = denied_q || err_c;
                    if (cnt_q == last_q) begin
                        state_d     = S_ACK;
                        d_valid_d   = 1'b1;
                        d_opcode_d  = 3'd0;
                        d_size_d    = size_q;
                        d_source_d  = source_q;
                        d_denied_d  = denied_q || err_c;
                        d_data_d    = 64'd0;
                        d_corrupt_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_RD: begin
                if (d_ready) begin
                    if (cnt_q == last_q) begin
                        state_d   = S_IDLE;
                        d_valid_d = 1'b0;
                    end else begin
                        cnt_d       = cnt_q + 3'd1;
                        d_data_d    = denied_q ? 64'd0 : mem[nxt_idx];
                        d_corrupt_d = denied_q || err_c;
                    end
                end
            end
            S_ACK: begin
                if (d_ready) begin
                    state_d   = S_IDLE;
                    d_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scratchpad is intentionally not reset; byte-lane masked writes.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            for (int b = 0; b < 8; b++) begin
                if (a_mask[b]) mem[wr_idx][b*8 +: 8] <= a_data[b*8 +: 8];
            end
        end
    end
endmodule
